// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of fifo_top's single write port.
// Bursts hold the port until last beat, MAX_BURST beats, or request drop.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic                          fifo_we,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              fsm, fsm_nxt;
  logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
  logic [ID_WIDTH-1:0] owner, owner_nxt;
  logic [ID_WIDTH-1:0] gid_q, gid_nxt;
  logic [CNT_W-1:0]    beat_cnt, beat_cnt_nxt;
  logic [ID_WIDTH-1:0] winner;
  logic [ID_WIDTH-1:0] cur_id;
  logic                found;
  logic                accept;
  int unsigned         idx;

  function automatic logic [ID_WIDTH-1:0] inc_id(input logic [ID_WIDTH-1:0] id);
    if (int'(id) == NUM_REQ - 1) return '0;
    return id + ID_WIDTH'(1);
  endfunction

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        winner = ID_WIDTH'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    fsm_nxt      = fsm;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    beat_cnt_nxt = beat_cnt;
    gid_nxt      = gid_q;
    accept       = 1'b0;
    cur_id       = gid_q;
    case (fsm)
      IDLE: begin
        if (found && !fifo_full) begin
          accept  = 1'b1;
          cur_id  = winner;
          gid_nxt = winner;
          if (req_last[winner] || MAX_BURST == 1) begin
            rr_ptr_nxt = inc_id(winner);
          end else begin
            fsm_nxt      = BURST;
            owner_nxt    = winner;
            beat_cnt_nxt = CNT_W'(1);
          end
        end
      end
      BURST: begin
        cur_id = owner;
        if (!req[owner]) begin
          fsm_nxt    = IDLE;
          rr_ptr_nxt = inc_id(owner);
        end else if (!fifo_full) begin
          accept       = 1'b1;
          gid_nxt      = owner;
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
          if (req_last[owner] || int'(beat_cnt) + 1 == MAX_BURST) begin
            fsm_nxt    = IDLE;
            rr_ptr_nxt = inc_id(owner);
          end
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm      <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      gid_q    <= '0;
    end else begin
      fsm      <= fsm_nxt;
      rr_ptr   <= rr_ptr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
      gid_q    <= gid_nxt;
    end
  end

  // Outputs are forced low combinationally so reset takes effect without a clock edge.
  assign fifo_we    = accept & ~rst;
  assign req_ack    = fifo_we ? (NUM_REQ'(1) << cur_id) : '0;
  assign fifo_wdata = fifo_we ? req_data[cur_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign grant_id   = rst ? '0 : cur_id;
  assign busy       = (fsm == BURST) & ~rst;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8).
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic        fifo_full;
  logic        fifo_we;
  logic [7:0]  fifo_wdata;
  logic [3:0]  req_ack;
  logic [1:0]  grant_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(
    .DATA_WIDTH(8),
    .NUM_REQ   (4),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_last  (req_last),
    .req_data  (req_data),
    .fifo_full (fifo_full),
    .fifo_we   (fifo_we),
    .fifo_wdata(fifo_wdata),
    .req_ack   (req_ack),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; req_last = 4'b1111; req_data = 32'hA5A5_A5A5; fifo_full = 1'b0;
    #1;
    checks++; if (fifo_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", fifo_we); end
    checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", req_ack); end
    checks++; if (fifo_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h expected 00", fifo_wdata); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid: got %0d expected 0", grant_id); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0; req = '0; req_last = '0; req_data = '0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; req_last = 4'b0001; req_data[7:0] = 8'hA5;
    #1;
    checks++; if (fifo_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b expected 1", fifo_we); end
    checks++; if (req_ack !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b expected 0001", req_ack); end
    checks++; if (fifo_wdata !== 8'hA5) begin errors++; $display("FAIL single_wdata: got %h expected a5", fifo_wdata); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_gid: got %0d expected 0", grant_id); end
    tick();
    req = 4'b1111; req_last = 4'b1111;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_rrptr: got %0d expected 1", grant_id); end
    tick();
    req = '0;
  endtask

  task automatic test_round_robin();
    int writes;
    logic [1:0] e_id;
    logic [3:0] e_ack;
    logic [7:0] e_data;
    do_reset();
    writes = 0;
    req = 4'b1111; req_last = 4'b1111; req_data = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
      #1;
      e_id = 2'(i % 4);
      e_ack = 4'b0001 << e_id;
      e_data = 8'h10 + 8'(e_id);
      checks++; if (grant_id !== e_id) begin errors++; $display("FAIL rr_gid[%0d]: got %0d expected %0d", i, grant_id, e_id); end
      checks++; if (req_ack !== e_ack) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, req_ack, e_ack); end
      checks++; if (fifo_wdata !== e_data) begin errors++; $display("FAIL rr_wdata[%0d]: got %h expected %h", i, fifo_wdata, e_data); end
      if (fifo_we === 1'b1) writes++;
      tick();
    end
    checks++; if (writes != 5) begin errors++; $display("FAIL rr_writes: got %0d expected 5", writes); end
    req = '0; req_last = '0;
    tick();
  endtask

  task automatic test_burst_last();
    logic [7:0] e_data;
    do_reset();
    req = 4'b0110; req_last = 4'b0000;
    req_data[15:8] = 8'h20; req_data[23:16] = 8'h40;
    for (int b = 0; b < 3; b++) begin
      if (b == 2) req_last = 4'b0010;
      #1;
      e_data = 8'h20 + 8'(b);
      checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL bl_ack[%0d]: got %b expected 0010", b, req_ack); end
      checks++; if (fifo_wdata !== e_data) begin errors++; $display("FAIL bl_wdata[%0d]: got %h expected %h", b, fifo_wdata, e_data); end
      checks++; if (busy !== (b > 0)) begin errors++; $display("FAIL bl_busy[%0d]: got %b expected %b", b, busy, (b > 0)); end
      tick();
      req_data[15:8] = req_data[15:8] + 8'd1;
    end
    req_last = 4'b0000;
    #1;
    checks++; if (req_ack !== 4'b0100) begin errors++; $display("FAIL bl_next_ack: got %b expected 0100", req_ack); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL bl_next_gid: got %0d expected 2", grant_id); end
    checks++; if (fifo_wdata !== 8'h40) begin errors++; $display("FAIL bl_next_wdata: got %h expected 40", fifo_wdata); end
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_max_burst();
    logic [7:0] e_data;
    do_reset();
    req = 4'b1001; req_last = 4'b0000;
    req_data[7:0] = 8'h50; req_data[31:24] = 8'h70;
    for (int b = 0; b < 4; b++) begin
      #1;
      e_data = 8'h50 + 8'(b);
      checks++; if (req_ack !== 4'b0001) begin errors++; $display("FAIL mb_ack[%0d]: got %b expected 0001", b, req_ack); end
      checks++; if (fifo_wdata !== e_data) begin errors++; $display("FAIL mb_wdata[%0d]: got %h expected %h", b, fifo_wdata, e_data); end
      checks++; if (busy !== (b > 0)) begin errors++; $display("FAIL mb_busy[%0d]: got %b expected %b", b, busy, (b > 0)); end
      tick();
      req_data[7:0] = req_data[7:0] + 8'd1;
    end
    #1;
    checks++; if (req_ack !== 4'b1000) begin errors++; $display("FAIL mb_release_ack: got %b expected 1000", req_ack); end
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL mb_release_gid: got %0d expected 3", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mb_release_busy: got %b expected 0", busy); end
    checks++; if (fifo_wdata !== 8'h70) begin errors++; $display("FAIL mb_release_wdata: got %h expected 70", fifo_wdata); end
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_full_stall();
    do_reset();
    req = 4'b1100; req_last = 4'b0000;
    req_data[23:16] = 8'h30; req_data[31:24] = 8'h60;
    for (int b = 0; b < 2; b++) begin
      #1;
      checks++; if (req_ack !== 4'b0100) begin errors++; $display("FAIL fs_ack[%0d]: got %b expected 0100", b, req_ack); end
      tick();
      req_data[23:16] = req_data[23:16] + 8'd1;
    end
    fifo_full = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (fifo_we !== 1'b0) begin errors++; $display("FAIL fs_stall_we[%0d]: got %b expected 0", c, fifo_we); end
      checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL fs_stall_ack[%0d]: got %b expected 0000", c, req_ack); end
      checks++; if (fifo_wdata !== 8'h00) begin errors++; $display("FAIL fs_stall_wdata[%0d]: got %h expected 00", c, fifo_wdata); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fs_stall_busy[%0d]: got %b expected 1", c, busy); end
      checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL fs_stall_gid[%0d]: got %0d expected 2", c, grant_id); end
      checks++; if (dut.beat_cnt !== 3'd2) begin errors++; $display("FAIL fs_stall_cnt[%0d]: got %0d expected 2", c, dut.beat_cnt); end
      tick();
    end
    fifo_full = 1'b0;
    #1;
    checks++; if (req_ack !== 4'b0100) begin errors++; $display("FAIL fs_resume_ack: got %b expected 0100", req_ack); end
    checks++; if (fifo_wdata !== 8'h32) begin errors++; $display("FAIL fs_resume_wdata: got %h expected 32", fifo_wdata); end
    tick();
    req_data[23:16] = req_data[23:16] + 8'd1;
    checks++; if (dut.beat_cnt !== 3'd3) begin errors++; $display("FAIL fs_resume_cnt: got %0d expected 3", dut.beat_cnt); end
    req = 4'b1000;
    #1;
    checks++; if (fifo_we !== 1'b0) begin errors++; $display("FAIL fs_drop_we: got %b expected 0", fifo_we); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fs_drop_busy: got %b expected 1", busy); end
    tick();
    #1;
    checks++; if (req_ack !== 4'b1000) begin errors++; $display("FAIL fs_after_ack: got %b expected 1000", req_ack); end
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL fs_after_gid: got %0d expected 3", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fs_after_busy: got %b expected 0", busy); end
    checks++; if (fifo_wdata !== 8'h60) begin errors++; $display("FAIL fs_after_wdata: got %h expected 60", fifo_wdata); end
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0010; req_last = 4'b0000; req_data = 32'h0000_1100;
    #1;
    checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL ar_first_ack: got %b expected 0010", req_ack); end
    tick();
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_busy_pre: got %b expected 1", busy); end
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL ar_gid_pre: got %0d expected 1", grant_id); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (fifo_we !== 1'b0) begin errors++; $display("FAIL ar_we: got %b expected 0", fifo_we); end
    checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL ar_ack: got %b expected 0000", req_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b expected 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL ar_gid: got %0d expected 0", grant_id); end
    tick();
    tick();
    rst = 1'b0; req = 4'b1111; req_last = 4'b1111; req_data = 32'h4433_2211;
    #1;
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL ar_restart_gid: got %0d expected 0", grant_id); end
    checks++; if (req_ack !== 4'b0001) begin errors++; $display("FAIL ar_restart_ack: got %b expected 0001", req_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_restart_busy: got %b expected 0", busy); end
    tick();
    // While full in IDLE: nothing accepted and grant_id holds the last winner.
    fifo_full = 1'b1;
    #1;
    checks++; if (fifo_we !== 1'b0) begin errors++; $display("FAIL ar_full_we: got %b expected 0", fifo_we); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL ar_full_gid: got %0d expected 0", grant_id); end
    tick();
    fifo_full = 1'b0;
    #1;
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL ar_unfull_gid: got %0d expected 1", grant_id); end
    checks++; if (fifo_wdata !== 8'h22) begin errors++; $display("FAIL ar_unfull_wdata: got %h expected 22", fifo_wdata); end
    tick();
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_last();
    test_max_burst();
    test_full_stall();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single write port of the team's FIFO (fifo_top) among NUM_REQ requesters.
- Supports bursts: a granted requester keeps the port until its last beat, until MAX_BURST beats, or until it drops its request.
- Respects the FIFO full flag as backpressure so no beat is ever presented while the FIFO is full.
- Sits between the requesters and fifo_top's i_we / i_data / fifo_full.

Parameters:
- DATA_WIDTH, 8: width of one data beat; matches the FIFO.
- NUM_REQ, 4: number of requesters; legal range 2..8.
- MAX_BURST, 4: maximum beats per grant before forced release; legal range 1..16.
- ID_WIDTH, $clog2(NUM_REQ): width of grant_id.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request, level-valid.
- req_last  in  NUM_REQ  marks the final beat of a requester's burst.
- req_data  in  NUM_REQ*DATA_WIDTH  requester k's data at [k*DATA_WIDTH +: DATA_WIDTH].
- fifo_full  in  1  from fifo_top.fifo_full.
- fifo_we  out  1  to fifo_top.i_we.
- fifo_wdata  out  DATA_WIDTH  to fifo_top.i_data.
- req_ack  out  NUM_REQ  one-hot; beat from requester k is accepted this cycle.
- grant_id  out  ID_WIDTH  index of the current winner or owner.
- busy  out  1  high while a burst is locked (BURST state).

Behaviour:
- Registered state: fsm (IDLE/BURST), rr_ptr, owner, beat_cnt. Reset value of all is 0 / IDLE.
- While rst is high, all outputs are 0.
- Outputs are combinational from state and inputs; zero-latency accept:
  - a beat is accepted in the cycle where fifo_we=1;
  - in that cycle, req_ack[grant_id]=1 and fifo_wdata=req_data[grant_id].
  - Requesters advance their data on ack.
- fifo_we=0 implies req_ack=0, fifo_wdata=0, and grant_id holds its last value (0 after reset).
- IDLE:
  - winner = first k with req[k]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - If there is no winner, or fifo_full=1: no accept, no state change. Arbitration is re-evaluated every cycle; nothing is locked while full.
  - Else accept the beat from the winner:
    - if req_last[winner]=1 or MAX_BURST=1: stay IDLE, rr_ptr<=winner+1 (mod NUM_REQ);
    - else: fsm<=BURST, owner<=winner, beat_cnt<=1.
- BURST:
  - grant_id=owner; busy=1.
  - fifo_we = req[owner] & ~fifo_full.
  - req[owner]=0: no accept; fsm<=IDLE, rr_ptr<=owner+1. The burst is abandoned and other requesters are eligible next cycle.
  - fifo_full=1 with req[owner]=1: stall. No ack; owner and beat_cnt are held.
  - On accept: beat_cnt<=beat_cnt+1. If req_last[owner]=1 or beat_cnt+1==MAX_BURST: fsm<=IDLE, rr_ptr<=owner+1.
- Requests from non-owners during BURST are ignored (held, not lost).
- beat_cnt is $clog2(MAX_BURST+1) bits wide and never wraps.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-burst: outputs drop to 0 immediately. After release, arbitration restarts from requester 0.
- Invariants:
  - req_ack is one-hot or zero;
  - fifo_we is never 1 while fifo_full=1;
  - ack count equals the number of FIFO writes.

Test Plan:
1. After reset, req=0001, req_last=0001, req_data[0]=8'hA5, fifo_full=0 -> same cycle fifo_we=1, req_ack=0001, fifo_wdata=A5, grant_id=0. Next cycle: IDLE, rr_ptr=1, busy=0.
2. req=1111, req_last=1111, held 5 cycles -> grant_id sequence 0,1,2,3,0; exactly one ack bit per cycle; 5 FIFO writes.
3. req=0110, requester 1 with req_last on its 3rd beat -> acks 0010 ×3, busy=1 on cycles 2–3; 4th cycle ack=0100, grant_id=2.
4. MAX_BURST=4; req=1001, req_last=0 -> 4 acks to requester 0, then release, 5th accepted beat goes to requester 3.
5. Mid-burst (owner 2, beat_cnt=2), fifo_full=1 for 2 cycles -> fifo_we=0, req_ack=0, busy=1, owner=2 held. After full clears, writes resume with beat_cnt continuing from 2. Then req[2] drops -> IDLE next cycle, requester 3 wins.
6. rst pulsed asynchronously mid-burst (owner 1) -> fifo_we, req_ack, busy and grant_id go to 0 without a clock edge. After release with req=1111, the first grant goes to requester 0.
